// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and op-class helpers for the iterative RV32M unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    function automatic logic is_div(mdu_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_rem(mdu_op_e op);
        return op inside {REM, REMU};
    endfunction

    function automatic logic is_signed_a(mdu_op_e op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic is_signed_b(mdu_op_e op);
        return op inside {MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one restoring-division step on unsigned magnitudes.
module mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] shl;
    logic [XLEN:0] diff;

    always_comb begin
        shl  = {rem_i, quo_i[XLEN-1]};
        diff = shl - {1'b0, div_i};
        // top bit of diff is the borrow: trial subtract failed, restore
        if (diff[XLEN]) begin
            rem_o = shl[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 RV32M multiply/divide unit for the execute stage.
// Works on magnitudes, one shift-add or restoring step per CALC cycle.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e state_q, state_d;
    mdu_op_e    op_q, op_d, op_in;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]   m_q, m_d, res_q, res_d;
    logic [XLEN-1:0]   dv_rem, dv_quo, mag_a, mag_b;
    logic [XLEN-1:0]   nh, nl, quo_s, rem_s, res_sel;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] prod_f, prod, prod_s;
    logic              sa, sb, accept, fast, last;

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i (hi_q),
        .quo_i (lo_q),
        .div_i (m_q),
        .rem_o (dv_rem),
        .quo_o (dv_quo)
    );

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE) & ~flush_i;
    assign result_o = valid_o ? res_q : '0;

    always_comb begin
        op_in   = mdu_op_e'(funct3_i);
        sa      = is_signed_a(op_in) & op_a_i[XLEN-1];
        sb      = is_signed_b(op_in) & op_b_i[XLEN-1];
        mag_a   = sa ? -op_a_i : op_a_i;
        mag_b   = sb ? -op_b_i : op_b_i;
        accept  = valid_i & ready_o & ~flush_i;
        fast    = FAST_MUL & ~is_div(op_q);
        add_sum = {1'b0, hi_q}
                + {1'b0, (lo_q[0] ? m_q : {XLEN{1'b0}})};
        prod_f  = {{XLEN{1'b0}}, m_q} * {{XLEN{1'b0}}, lo_q};

        // {hi, lo} is product for multiplies, {rem, quo} for divides
        if (fast)
            {nh, nl} = prod_f;
        else if (is_div(op_q))
            {nh, nl} = {dv_rem, dv_quo};
        else
            {nh, nl} = {add_sum[XLEN:1], add_sum[0], lo_q[XLEN-1:1]};

        prod   = {nh, nl};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -nl : nl;
        rem_s  = neg_q ? -nh : nh;
        if (is_div(op_q))
            res_sel = is_rem(op_q) ? rem_s : quo_s;
        else if (op_q == MUL)
            res_sel = prod_s[XLEN-1:0];
        else
            res_sel = prod_s[2*XLEN-1:XLEN];
        last = fast | (cnt_q == CNT_LAST);

        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    cnt_d   = '0;
                    hi_d    = '0;
                    state_d = CALC;
                    if (is_div(op_in)) begin
                        neg_d = is_rem(op_in) ? sa : (sa ^ sb);
                        lo_d  = mag_a;
                        m_d   = mag_b;
                        if (op_b_i == '0) begin
                            res_d   = is_rem(op_in) ? op_a_i : '1;
                            state_d = DONE;
                        end else if (is_signed_b(op_in) &&
                                     op_a_i == MIN_VAL &&
                                     op_b_i == '1) begin
                            res_d   = is_rem(op_in) ? '0 : MIN_VAL;
                            state_d = DONE;
                        end
                    end else begin
                        neg_d = sa ^ sb;
                        lo_d  = mag_b;
                        m_d   = mag_a;
                        if (op_a_i == '0 || op_b_i == '0) begin
                            res_d   = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
            CALC: begin
                hi_d = nh;
                lo_d = nl;
                if (last) begin
                    res_d   = res_sel;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= MUL;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed and random checks of two unit configurations
// (XLEN=32 iterative, XLEN=16 fast multiply) against an arithmetic model.
module tb_mdu_iterative;
    import mdu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rstn, vld, rdy, fls;
    logic [1:0]       vo, ro, bo;
    logic [1:0][2:0]  f_in;
    logic [1:0][31:0] a_in, b_in, rout;
    logic [31:0]      r32;
    logic [15:0]      r16;

    int   checks = 0;
    int   errors = 0;
    int   n;
    logic seen;

    assign rout[0] = r32;
    assign rout[1] = {16'h0, r16};

    mdu_iterative #(.XLEN(32), .FAST_MUL(1'b0)) dut (
        .clk_i(clk), .rst_ni(rstn[0]),
        .valid_i(vld[0]), .ready_o(ro[0]),
        .funct3_i(f_in[0]),
        .op_a_i(a_in[0]), .op_b_i(b_in[0]),
        .flush_i(fls[0]), .valid_o(vo[0]),
        .ready_i(rdy[0]), .result_o(r32),
        .busy_o(bo[0])
    );

    mdu_iterative #(.XLEN(16), .FAST_MUL(1'b1)) dut16 (
        .clk_i(clk), .rst_ni(rstn[1]),
        .valid_i(vld[1]), .ready_o(ro[1]),
        .funct3_i(f_in[1]),
        .op_a_i(a_in[1][15:0]), .op_b_i(b_in[1][15:0]),
        .flush_i(fls[1]), .valid_o(vo[1]),
        .ready_i(rdy[1]), .result_o(r16),
        .busy_o(bo[1])
    );

    function automatic logic [31:0] wmask(int w);
        return (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // Reference result from plain 64-bit arithmetic on signed/unsigned views
    function automatic logic [31:0] ref_res(int w, logic [2:0] f,
                                            logic [31:0] a, logic [31:0] b);
        longint ua, ub, sa, sb, q;
        logic [63:0] p;
        ua = longint'(a & wmask(w));
        ub = longint'(b & wmask(w));
        sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
        p  = '0;
        q  = 0;
        case (f)
            3'd0, 3'd1: p = 64'(sa * sb);
            3'd2:       p = 64'(sa * ub);
            3'd3:       p = 64'(ua * ub);
            default:    p = '0;
        endcase
        case (f)
            3'd0: q = longint'(p);
            3'd1, 3'd2, 3'd3: q = longint'(p >> w);
            3'd4: if (ub == 0) q = -1; else q = sa / sb;
            3'd5: if (ub == 0) q = -1; else q = ua / ub;
            3'd6: if (ub == 0) q = ua; else q = sa % sb;
            default: if (ub == 0) q = ua; else q = ua % ub;
        endcase
        return 32'(q) & wmask(w);
    endfunction

    function automatic int lat_of(int w, bit fast, logic [2:0] f,
                                  logic [31:0] a, logic [31:0] b);
        logic [31:0] m, am, bm;
        m  = wmask(w);
        am = a & m;
        bm = b & m;
        if (f[2]) begin
            if (bm == 0) return 1;
            if (!f[0] && am == (32'd1 << (w - 1)) && bm == m) return 1;
            return w + 1;
        end
        if (am == 0 || bm == 0) return 1;
        return fast ? 2 : w + 1;
    endfunction

    function automatic logic [31:0] pick(int w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'd1 << (w - 1);
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom_range(0, 15);
            4: v = -32'($urandom_range(1, 15));
            default: v = $urandom;
        endcase
        return v & wmask(w);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_chk
        localparam int W  = (g == 0) ? 32 : 16;
        localparam bit FM = (g == 1);
        logic        act = 1'b0;
        int          cnt = 0;
        int          lat = 0;
        int          nops = 0;
        logic [31:0] res = '0;
        logic        ev;
        logic [34:0] got, expv;

        always @(posedge clk or negedge rstn[g]) begin
            if (!rstn[g]) begin
                act <= 1'b0;
                cnt <= 0;
            end else if (fls[g]) begin
                act <= 1'b0;
            end else if (act) begin
                if (cnt + 1 >= lat && rdy[g]) act <= 1'b0;
                else cnt <= cnt + 1;
            end else if (vld[g]) begin
                act  <= 1'b1;
                cnt  <= 0;
                lat  <= lat_of(W, FM, f_in[g], a_in[g], b_in[g]);
                res  <= ref_res(W, f_in[g], a_in[g], b_in[g]);
                nops <= nops + 1;
            end
        end

        always @(negedge clk) begin
            ev   = act && (cnt + 1 >= lat) && !fls[g];
            expv = {ev, !act, act, (ev ? res : 32'h0)};
            got  = {vo[g], ro[g], bo[g], rout[g]};
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL mon%0d t=%0t v/r/b/res got %b%b%b %h exp %b%b%b %h",
                         g, $time, got[34], got[33], got[32], got[31:0],
                         expv[34], expv[33], expv[32], expv[31:0]);
            end
        end
    end

    task automatic chk(string nm, logic [63:0] got, logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, expv);
        end
    endtask

    task automatic wait_idle(int g);
        int k = 0;
        @(posedge clk); #1;
        while (!ro[g] && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle", 64'(ro[g]), 64'd1);
    endtask

    task automatic run_op(int g, logic [2:0] f, logic [31:0] a,
                          logic [31:0] b, logic [31:0] er, int el, string nm);
        int k = 0;
        wait_idle(g);
        f_in[g] = f;
        a_in[g] = a;
        b_in[g] = b;
        vld[g]  = 1'b1;
        rdy[g]  = 1'b1;
        @(posedge clk); #1;
        vld[g] = 1'b0;
        while (!vo[g] && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk({nm, " lat"}, 64'(k + 1), 64'(el));
        chk({nm, " res"}, 64'(rout[g]), 64'(er));
    endtask

    task automatic rand_run(int g, int ncyc);
        int w = (g == 0) ? 32 : 16;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            vld[g]  = 1'($urandom_range(0, 1));
            rdy[g]  = ($urandom_range(0, 3) != 0);
            fls[g]  = ($urandom_range(0, 99) == 0);
            f_in[g] = 3'($urandom);
            a_in[g] = pick(w);
            b_in[g] = pick(w);
        end
        @(posedge clk); #1;
        vld[g] = 1'b0;
        fls[g] = 1'b0;
        rdy[g] = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 2'b00;
        vld  = 2'b00;
        rdy  = 2'b11;
        fls  = 2'b00;
        f_in = '0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset0", {vo[0], ro[0], bo[0], rout[0]}, {3'b010, 32'h0});
        chk("reset1", {vo[1], ro[1], bo[1], rout[1]}, {3'b010, 32'h0});
        rstn = 2'b11;

        run_op(0, MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        run_op(0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(0, MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33, "mulhsu");
        run_op(0, DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, "div");
        run_op(0, REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, "rem");
        run_op(0, DIVU,   32'd100,      32'd7,         32'd14,        33, "divu");
        run_op(0, REMU,   32'd100,      32'd7,         32'd2,         33, "remu");
        run_op(0, DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div ovf");
        run_op(0, REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "rem ovf");
        run_op(0, DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF, 1, "divu0");
        run_op(0, REMU,   32'd5,        32'd0,         32'd5,         1, "remu0");
        run_op(1, MUL,    32'h7FFF,     32'd2,         32'hFFFE,      2, "mul16");

        // result held under backpressure, new request ignored
        wait_idle(0);
        f_in[0] = DIVU;
        a_in[0] = 32'd100;
        b_in[0] = 32'd7;
        vld[0]  = 1'b1;
        rdy[0]  = 1'b0;
        @(posedge clk); #1;
        f_in[0] = MUL;
        a_in[0] = 32'd3;
        b_in[0] = 32'd3;
        n = 0;
        while (!vo[0] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp lat", 64'(n + 1), 64'd33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp hold", {vo[0], ro[0], rout[0]}, {2'b10, 32'd14});
        end
        rdy[0] = 1'b1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        chk("bp release", {vo[0], ro[0]}, 2'b01);

        // flush in the middle of CALC
        wait_idle(0);
        f_in[0] = DIVU;
        a_in[0] = 32'd1000;
        b_in[0] = 32'd7;
        vld[0]  = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        fls[0] = 1'b1;
        chk("fl calc", {vo[0], bo[0]}, 2'b01);
        @(posedge clk); #1;
        fls[0] = 1'b0;
        chk("fl idle", {ro[0], bo[0], vo[0]}, 3'b100);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | vo[0];
        end
        chk("fl novalid", 64'(seen), 64'd0);
        run_op(0, DIVU, 32'd9, 32'd3, 32'd3, 33, "divu 9/3");

        // asynchronous reset mid-CALC
        wait_idle(0);
        f_in[0] = MUL;
        a_in[0] = 32'h0001_2345;
        b_in[0] = 32'h0000_0777;
        vld[0]  = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstn[0] = 1'b0;
        #1;
        chk("async rst", {vo[0], ro[0], bo[0], rout[0]}, {3'b010, 32'h0});
        @(posedge clk);
        #2;
        rstn[0] = 1'b1;
        run_op(0, MUL, 32'd3, 32'd4, 32'd12, 33, "mul after rst");

        fork
            rand_run(0, 30000);
            rand_run(1, 30000);
        join
        repeat (60) @(posedge clk);
        #1;
        chk("ops32 >= 200", 64'(g_chk[0].nops >= 200), 64'd1);
        chk("ops16 >= 200", 64'(g_chk[1].nops >= 200), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
